// File: rtl/timer0_counter_if.sv
// I/O register bus shared between the CPU side (master) and timer0_counter (slave).
// The read data is registered inside the slave.
interface timer0_counter_if;
    logic [5:0] io_a;
    logic       io_we;
    logic       io_re;
    logic [7:0] io_di;
    logic [7:0] io_do;

    modport master (
        output io_a,
        output io_we,
        output io_re,
        output io_di,
        input  io_do
    );

    modport slave (
        input  io_a,
        input  io_we,
        input  io_re,
        input  io_di,
        output io_do
    );
endinterface

// File: rtl/timer0_counter.sv
// 8-bit timer/counter 0: normal/CTC counting, compare match, overflow/compare flags,
// level interrupt requests and an OC0 toggle pin, all registers on the 6-bit I/O bus.
module timer0_counter #(
    parameter logic [5:0] base_addr = 6'h12
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    timer0_counter_if.slave    bus,
    input  logic               clk_t0,
    output logic [2:0]         cs0,
    output logic               irq_ovf,
    output logic               irq_cmp,
    input  logic               irq_ovf_ack,
    input  logic               irq_cmp_ack,
    output logic               oc0
);

    localparam logic [5:0] ADDR_TCNT  = base_addr;
    localparam logic [5:0] ADDR_OCR   = base_addr + 6'd1;
    localparam logic [5:0] ADDR_TCCR  = base_addr + 6'd2;
    localparam logic [5:0] ADDR_TIFR  = base_addr + 6'd3;
    localparam logic [5:0] ADDR_TIMSK = base_addr + 6'd4;

    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] ocr_q, ocr_d;
    logic [2:0] cs_q, cs_d;
    logic       ctc_q, ctc_d;
    logic       com_q, com_d;
    logic       tov_q, tov_d;
    logic       ocf_q, ocf_d;
    logic       toie_q, toie_d;
    logic       ocie_q, ocie_d;
    logic       oc0_q, oc0_d;
    logic [7:0] io_do_q, io_do_d;

    logic       wr_tcnt, wr_ocr, wr_tccr, wr_tifr, wr_timsk;
    logic       tick, match;
    logic       tov_set, ocf_set, tov_clr, ocf_clr;
    logic [7:0] rd_data;

    always_comb begin
        wr_tcnt  = bus.io_we && (bus.io_a == ADDR_TCNT);
        wr_ocr   = bus.io_we && (bus.io_a == ADDR_OCR);
        wr_tccr  = bus.io_we && (bus.io_a == ADDR_TCCR);
        wr_tifr  = bus.io_we && (bus.io_a == ADDR_TIFR);
        wr_timsk = bus.io_we && (bus.io_a == ADDR_TIMSK);

        case (cs_q)
            3'd0:    tick = 1'b0;
            3'd1:    tick = 1'b1;
            default: tick = clk_t0;
        endcase
        match = (tcnt_q == ocr_q);

        tcnt_d  = tcnt_q;
        oc0_d   = oc0_q;
        tov_set = 1'b0;
        ocf_set = 1'b0;

        // A CPU write to TCNT0 suppresses counting and all compare/overflow evaluation.
        if (wr_tcnt) begin
            tcnt_d = bus.io_di;
        end else if (tick) begin
            if (match) begin
                ocf_set = 1'b1;
                if (com_q) begin
                    oc0_d = ~oc0_q;
                end
            end
            if (match && ctc_q) begin
                tcnt_d = 8'h00;
            end else if (tcnt_q == 8'hFF) begin
                tcnt_d  = 8'h00;
                tov_set = ~ctc_q;
            end else begin
                tcnt_d = tcnt_q + 8'd1;
            end
        end

        // Hardware set beats any clear arriving on the same cycle.
        tov_clr = irq_ovf_ack | (wr_tifr & bus.io_di[0]);
        ocf_clr = irq_cmp_ack | (wr_tifr & bus.io_di[1]);
        tov_d   = tov_set | (tov_q & ~tov_clr);
        ocf_d   = ocf_set | (ocf_q & ~ocf_clr);

        ocr_d  = wr_ocr   ? bus.io_di      : ocr_q;
        cs_d   = wr_tccr  ? bus.io_di[2:0] : cs_q;
        ctc_d  = wr_tccr  ? bus.io_di[3]   : ctc_q;
        com_d  = wr_tccr  ? bus.io_di[4]   : com_q;
        toie_d = wr_timsk ? bus.io_di[0]   : toie_q;
        ocie_d = wr_timsk ? bus.io_di[1]   : ocie_q;

        case (bus.io_a)
            ADDR_TCNT:  rd_data = tcnt_q;
            ADDR_OCR:   rd_data = ocr_q;
            ADDR_TCCR:  rd_data = {3'b000, com_q, ctc_q, cs_q};
            ADDR_TIFR:  rd_data = {6'b000000, ocf_q, tov_q};
            ADDR_TIMSK: rd_data = {6'b000000, ocie_q, toie_q};
            default:    rd_data = 8'h00;
        endcase
        io_do_d = bus.io_re ? rd_data : io_do_q;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tcnt_q  <= 8'h00;
            ocr_q   <= 8'h00;
            cs_q    <= 3'd0;
            ctc_q   <= 1'b0;
            com_q   <= 1'b0;
            tov_q   <= 1'b0;
            ocf_q   <= 1'b0;
            toie_q  <= 1'b0;
            ocie_q  <= 1'b0;
            oc0_q   <= 1'b0;
            io_do_q <= 8'h00;
        end else begin
            tcnt_q  <= tcnt_d;
            ocr_q   <= ocr_d;
            cs_q    <= cs_d;
            ctc_q   <= ctc_d;
            com_q   <= com_d;
            tov_q   <= tov_d;
            ocf_q   <= ocf_d;
            toie_q  <= toie_d;
            ocie_q  <= ocie_d;
            oc0_q   <= oc0_d;
            io_do_q <= io_do_d;
        end
    end

    assign bus.io_do = io_do_q;
    assign cs0       = cs_q;
    assign irq_ovf   = tov_q & toie_q;
    assign irq_cmp   = ocf_q & ocie_q;
    assign oc0       = oc0_q;

endmodule
